npu_engine_dispatcher: RTL and testbench

- Issues decoded microcode instructions to the 8 compute/DMA engines identified by engine_id_t: GEMM, SOFTMAX, LAYERNORM, GELU, VEC, DMA, RMSNORM and ROPE.
- Tracks per-engine busy state and enforces barriers.
- Detects hangs and protocol errors.
- Sits between the microcode fetch/decode unit and the engines. Drives the CTRL/STATUS semantics: start in, done/busy/error out.

---
 rtl/npu_pkg.sv | 34 +++
 rtl/npu_engine_dispatcher_if.sv | 28 ++
 rtl/npu_watchdog.sv | 26 ++
 rtl/npu_engine_dispatcher.sv | 163 ++++++++++++++++
 tb/tb_npu_engine_dispatcher.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared types for the NPU engine dispatcher: engine identifiers, FSM states and error codes.
package npu_pkg;

  typedef enum logic [2:0] {
    ENG_GEMM      = 3'd0,
    ENG_SOFTMAX   = 3'd1,
    ENG_LAYERNORM = 3'd2,
    ENG_GELU      = 3'd3,
    ENG_VEC       = 3'd4,
    ENG_DMA       = 3'd5,
    ENG_RMSNORM   = 3'd6,
    ENG_ROPE      = 3'd7
  } engine_id_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    FINISH = 3'd3,
    ERROR  = 3'd4
  } disp_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_SPURIOUS = 2'd2
  } disp_err_t;

  // States in which engines may be outstanding and completions are expected.
  function automatic logic run_active(disp_state_t s);
    return (s == RUN) || (s == DRAIN) || (s == FINISH);
  endfunction

endpackage

// File: rtl/npu_engine_dispatcher_if.sv
// Instruction handshake from decode plus the start/done lines to the engines.
interface npu_engine_dispatcher_if #(
  parameter int NUM_ENG = 8,
  parameter int ARG_W   = 64
) ();
  import npu_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  engine_id_t         instr_eng;
  logic               instr_barrier;
  logic               instr_last;
  logic [ARG_W-1:0]   instr_payload;
  logic [NUM_ENG-1:0] eng_start;
  logic [ARG_W-1:0]   eng_payload;
  logic [NUM_ENG-1:0] eng_done;
  logic [NUM_ENG-1:0] eng_busy;

  modport master (
    output instr_valid, instr_eng, instr_barrier, instr_last, instr_payload, eng_done,
    input  instr_ready, eng_start, eng_payload, eng_busy
  );

  modport slave (
    input  instr_valid, instr_eng, instr_barrier, instr_last, instr_payload, eng_done,
    output instr_ready, eng_start, eng_payload, eng_busy
  );
endinterface

// File: rtl/npu_watchdog.sv
// Saturating stall counter; expired is high once the count sits at all-ones.
module npu_watchdog #(
  parameter int TMO_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TMO_W'(1);
    end
  end

  assign expired = &count;

endmodule

// File: rtl/npu_engine_dispatcher.sv
// Issues decoded instructions to the NPU engines, tracks per-engine busy, barriers and faults.
// IDLE: wait start | RUN: issue | DRAIN: barrier wait | FINISH: last wait | ERROR: sticky fault
module npu_engine_dispatcher
  import npu_pkg::*;
#(
  parameter int NUM_ENG = 8,
  parameter int ARG_W   = 64,
  parameter int CNT_W   = 16,
  parameter int TMO_W   = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    soft_reset,
  npu_engine_dispatcher_if.slave  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [CNT_W-1:0]        instr_count
);

  disp_state_t        state, state_next;
  disp_err_t          err_next;
  logic [NUM_ENG-1:0] eng_sel;
  logic [NUM_ENG-1:0] eng_busy_q;
  logic [NUM_ENG-1:0] eng_start_q;
  logic [ARG_W-1:0]   eng_payload_q;
  logic               active, any_done, accept, issue;
  logic               spurious, timeout;
  logic               go_run, go_finish, go_error;
  logic               wdg_enable, wdg_clear, wdg_expired;

  assign eng_sel  = NUM_ENG'(1) << bus.instr_eng;
  assign active   = run_active(state);
  assign any_done = |bus.eng_done;

  // Ready looks only at the registered busy flags, so a same-cycle done leaves a bubble.
  assign bus.instr_ready = (state == RUN) &&
                           (bus.instr_barrier || ((eng_busy_q & eng_sel) == '0));
  assign accept = bus.instr_valid && bus.instr_ready;
  assign issue  = accept && !bus.instr_barrier;

  assign spurious = active && ((bus.eng_done & ~eng_busy_q) != '0);
  assign timeout  = active && wdg_expired;

  assign wdg_enable = active && (eng_busy_q != '0);
  assign wdg_clear  = soft_reset || !wdg_enable || accept || any_done;

  npu_watchdog #(.TMO_W(TMO_W)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wdg_clear),
    .enable  (wdg_enable),
    .expired (wdg_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    err_next   = ERR_NONE;
    go_run     = 1'b0;
    go_finish  = 1'b0;
    go_error   = 1'b0;
    if (soft_reset) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            state_next = RUN;
            go_run     = 1'b1;
          end
        end
        RUN, DRAIN, FINISH: begin
          if (spurious) begin
            state_next = ERROR;
            go_error   = 1'b1;
            err_next   = ERR_SPURIOUS;
          end else if (timeout) begin
            state_next = ERROR;
            go_error   = 1'b1;
            err_next   = ERR_TIMEOUT;
          end else if (state == RUN) begin
            if (accept && bus.instr_last) begin
              state_next = FINISH;
            end else if (accept && bus.instr_barrier) begin
              state_next = DRAIN;
            end
          end else if (eng_busy_q == '0) begin
            state_next = (state == DRAIN) ? RUN : IDLE;
            go_finish  = (state == FINISH);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy_q    <= '0;
      eng_start_q   <= '0;
      eng_payload_q <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 2'd0;
      instr_count   <= '0;
    end else if (soft_reset) begin
      eng_busy_q    <= '0;
      eng_start_q   <= '0;
      eng_payload_q <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 2'd0;
      instr_count   <= '0;
    end else begin
      eng_start_q <= '0;
      if (go_run) begin
        eng_busy_q  <= '0;
        busy        <= 1'b1;
        done        <= 1'b0;
        error       <= 1'b0;
        err_code    <= 2'd0;
        instr_count <= '0;
      end else if (go_error) begin
        // Busy flags are frozen so the faulting engine set stays visible.
        error    <= 1'b1;
        err_code <= err_next;
        busy     <= 1'b0;
      end else begin
        if (active) begin
          eng_busy_q <= (eng_busy_q & ~bus.eng_done) | (issue ? eng_sel : '0);
        end
        if (accept) begin
          instr_count <= instr_count + CNT_W'(1);
        end
        if (issue) begin
          eng_start_q   <= eng_sel;
          eng_payload_q <= bus.instr_payload;
        end
        if (go_finish) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

  assign bus.eng_start   = eng_start_q;
  assign bus.eng_payload = eng_payload_q;
  assign bus.eng_busy    = eng_busy_q;

endmodule

// File: tb/tb_npu_engine_dispatcher.sv
// Directed bench: scoreboarded engine start pulses plus handshake timing, barrier, error and reset checks.
module tb_npu_engine_dispatcher;
  import npu_pkg::*;

  typedef struct {
    logic [7:0]  oh;
    logic [63:0] pl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, soft_reset, start_t, soft_reset_t;
  logic        busy, done, error, busy_t, done_t, error_t;
  logic [1:0]  err_code, err_code_t;
  logic [15:0] instr_count, instr_count_t;
  logic [7:0]  done_auto = '0;
  logic [7:0]  done_man  = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          dly [8];
  int          cd [8];
  int          start_cyc [8];
  int          done_cyc [8];
  exp_t        sb [$];

  npu_engine_dispatcher_if #(.NUM_ENG(8), .ARG_W(64)) bus ();
  npu_engine_dispatcher_if #(.NUM_ENG(8), .ARG_W(64)) bus_t ();

  npu_engine_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .soft_reset(soft_reset), .bus(bus),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .instr_count(instr_count)
  );

  npu_engine_dispatcher #(.TMO_W(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start_t), .soft_reset(soft_reset_t), .bus(bus_t),
    .busy(busy_t), .done(done_t), .error(error_t), .err_code(err_code_t),
    .instr_count(instr_count_t)
  );

  assign bus.eng_done = done_auto | done_man;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Engine model: done pulse dly[i] cycles after each start (0 = never), plus scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    done_auto = '0;
    for (int i = 0; i < 8; i++) begin
      if (cd[i] > 0) begin
        cd[i] = cd[i] - 1;
        if (cd[i] == 0) begin
          done_auto[i] = 1'b1;
          done_cyc[i]  = cyc;
        end
      end
      if (bus.eng_start[i]) begin
        start_cyc[i] = cyc;
        cd[i]        = dly[i];
      end
    end
    if (bus.eng_start != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_start", 64'(bus.eng_start), 64'd0);
      end else begin
        e = sb.pop_front();
        check("start_onehot", 64'(bus.eng_start), 64'(e.oh));
        check("start_payload", bus.eng_payload, e.pl);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input engine_id_t e, input logic bar, input logic last,
                      input logic [63:0] pl, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    bus.instr_valid   = 1'b1;
    bus.instr_eng     = e;
    bus.instr_barrier = bar;
    bus.instr_last    = last;
    bus.instr_payload = pl;
    for (int n = 0; n < 200 && !got; n++) begin
      #1;
      if (bus.instr_ready) begin
        got = 1'b1;
        acc = cyc;
        if (!bar) sb.push_back('{oh: 8'(1) << e, pl: pl});
      end
      @(negedge clk);
    end
    bus.instr_valid   = 1'b0;
    bus.instr_barrier = 1'b0;
    bus.instr_last    = 1'b0;
    check("send_accepted", 64'(got), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 300 && !done; n++) @(negedge clk);
    #1;
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, observed time %0t", $time);
    $fatal(1);
  end

  initial begin
    int a1, a2, a3, d1, g, t0, ecyc;
    rst_n = 1'b0; start = 1'b0; soft_reset = 1'b0; start_t = 1'b0; soft_reset_t = 1'b0;
    bus.instr_valid = 1'b0; bus.instr_eng = ENG_GEMM; bus.instr_barrier = 1'b0;
    bus.instr_last = 1'b0; bus.instr_payload = '0;
    bus_t.instr_valid = 1'b0; bus_t.instr_eng = ENG_GEMM; bus_t.instr_barrier = 1'b0;
    bus_t.instr_last = 1'b0; bus_t.instr_payload = '0; bus_t.eng_done = '0;
    for (int i = 0; i < 8; i++) dly[i] = 0;

    repeat (3) @(negedge clk);
    check("rst_status", 64'({busy, done, error, err_code}), 64'd0);
    check("rst_count", 64'(instr_count), 64'd0);
    check("rst_eng", 64'({bus.eng_busy, bus.eng_start, bus.instr_ready}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run
    dly[ENG_GEMM] = 5; dly[ENG_VEC] = 5; dly[ENG_SOFTMAX] = 5;
    pulse_start();
    #1 check("basic_busy", 64'(busy), 64'd1);
    send(ENG_GEMM,    1'b0, 1'b0, 64'hA000_0000_0000_00A1, a1);
    send(ENG_VEC,     1'b0, 1'b0, 64'hB000_0000_0000_00B2, a2);
    send(ENG_SOFTMAX, 1'b0, 1'b1, 64'hC000_0000_0000_00C3, a3);
    wait_done("basic_done");
    check("basic_busy_low", 64'(busy), 64'd0);
    check("basic_count", 64'(instr_count), 64'd3);
    check("basic_eng_busy", 64'(bus.eng_busy), 64'd0);

    // Back-to-back same engine
    dly[ENG_GEMM] = 10;
    pulse_start();
    #1 check("b2b_done_cleared", 64'(done), 64'd0);
    check("b2b_count_cleared", 64'(instr_count), 64'd0);
    send(ENG_GEMM, 1'b0, 1'b0, 64'h1111_0000_0000_0001, a1);
    send(ENG_GEMM, 1'b0, 1'b1, 64'h2222_0000_0000_0002, a2);
    d1 = done_cyc[ENG_GEMM];
    check("b2b_first_done", 64'(d1), 64'(a1 + 11));
    check("b2b_accept_after_done", 64'(a2), 64'(d1 + 1));
    @(negedge clk);
    check("b2b_start_after_done", 64'(start_cyc[ENG_GEMM]), 64'(d1 + 2));
    wait_done("b2b_done");
    check("b2b_count", 64'(instr_count), 64'd2);

    // Barrier: GEMM done at t0+20, DMA at t0+30, GELU accepted at t0+32
    dly[ENG_GEMM] = 19; dly[ENG_DMA] = 28; dly[ENG_GELU] = 3;
    pulse_start();
    send(ENG_GEMM, 1'b0, 1'b0, 64'h3333_0000_0000_0003, t0);
    send(ENG_DMA,  1'b0, 1'b0, 64'h4444_0000_0000_0004, a2);
    send(ENG_GEMM, 1'b1, 1'b0, 64'h0,                   a3);
    send(ENG_GELU, 1'b0, 1'b1, 64'h5555_0000_0000_0005, g);
    check("bar_gemm_done", 64'(done_cyc[ENG_GEMM]), 64'(t0 + 20));
    check("bar_dma_done", 64'(done_cyc[ENG_DMA]), 64'(t0 + 30));
    check("bar_gelu_accept", 64'(g), 64'(t0 + 32));
    wait_done("bar_done");
    check("bar_count", 64'(instr_count), 64'd4);

    // Spurious done while nothing is outstanding
    pulse_start();
    @(negedge clk);
    done_man = 8'h08;
    @(negedge clk);
    done_man = 8'h00;
    #1 check("spur_error", 64'(error), 64'd1);
    check("spur_code", 64'(err_code), 64'd2);
    check("spur_busy", 64'(busy), 64'd0);
    check("spur_ready", 64'(bus.instr_ready), 64'd0);
    dly[ENG_VEC] = 4;
    pulse_start();
    #1 check("spur_restart", 64'({error, err_code, busy}), 64'b0001);
    send(ENG_VEC, 1'b0, 1'b1, 64'h6666_0000_0000_0006, a1);
    wait_done("spur_rerun_done");
    check("spur_rerun_count", 64'(instr_count), 64'd1);

    // Timeout on the TMO_W=4 instance
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    bus_t.instr_valid = 1'b1; bus_t.instr_eng = ENG_ROPE;
    bus_t.instr_payload = 64'h7777_0000_0000_0007;
    #1 check("tmo_ready", 64'(bus_t.instr_ready), 64'd1);
    a1 = cyc;
    @(negedge clk);
    bus_t.instr_valid = 1'b0;
    #1 check("tmo_start", 64'(bus_t.eng_start), 64'h80);
    check("tmo_payload", bus_t.eng_payload, 64'h7777_0000_0000_0007);
    for (int n = 0; n < 40 && !error_t; n++) begin
      @(negedge clk);
      #1;
    end
    ecyc = cyc;
    check("tmo_error", 64'(error_t), 64'd1);
    check("tmo_window", 64'((ecyc >= a1 + 16) && (ecyc <= a1 + 17)), 64'd1);
    check("tmo_code", 64'(err_code_t), 64'd1);
    check("tmo_busy", 64'(busy_t), 64'd0);
    check("tmo_eng_held", 64'(bus_t.eng_busy), 64'h80);

    // Asynchronous reset mid-run
    @(negedge clk);
    dly[ENG_GEMM] = 0; dly[ENG_VEC] = 0;
    pulse_start();
    send(ENG_GEMM, 1'b0, 1'b0, 64'h8888_0000_0000_0008, a1);
    send(ENG_VEC,  1'b0, 1'b0, 64'h9999_0000_0000_0009, a2);
    @(negedge clk);
    #1 check("arst_pre_busy", 64'(bus.eng_busy), 64'h11);
    #2 rst_n = 1'b0;
    #1 check("arst_eng", 64'({bus.eng_busy, bus.eng_start}), 64'd0);
    check("arst_payload", bus.eng_payload, 64'd0);
    check("arst_status", 64'({busy, done, error, err_code, bus.instr_ready}), 64'd0);
    check("arst_count", 64'(instr_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Soft reset while waiting in FINISH
    pulse_start();
    send(ENG_GEMM, 1'b0, 1'b1, 64'hAAAA_0000_0000_000A, a1);
    #1 check("srst_pre_busy", 64'(busy), 64'd1);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    #1 check("srst_status", 64'({busy, done, error, err_code}), 64'd0);
    check("srst_eng", 64'(bus.eng_busy), 64'd0);
    check("srst_count", 64'(instr_count), 64'd0);
    check("srst_ready", 64'(bus.instr_ready), 64'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
